// File: rtl/pixel_bbox_tracker.sv
// -----------------------------------------------------------------------------
// pixel_bbox_tracker
//
// Sits behind the per-pixel colour classifier. Tracks raster position within a
// frame, accumulates a bounding box and a pixel count for every non-background
// class (1..7), and copies the finished frame into a result bank that the rover
// control path reads by class index after each frame_done pulse.
//
// Ports
//   clk                   single clock, rising edge
//   rst                   synchronous active-high reset
//   in_valid              classified pixel present this cycle
//   in_sop                first pixel of a frame (qualified by in_valid)
//   in_eop                last pixel of a frame (qualified by in_valid)
//   pixel_classification  pixel class, 0 = background, 1..7 = colours
//   rd_class              class index to read from the result bank
//   rd_x_min / rd_x_max   committed horizontal extent of rd_class (registered)
//   rd_y_min / rd_y_max   committed vertical extent of rd_class (registered)
//   rd_count              committed pixel count of rd_class (registered)
//   rd_found              rd_count >= MIN_COUNT (registered)
//   frame_done            one-cycle pulse when the bank is updated
//   frame_error           qualifies frame_done: committed frame had bad geometry
//   busy                  high while a frame is being accumulated
// -----------------------------------------------------------------------------
module pixel_bbox_tracker #(
  parameter int IMAGE_W   = 640,
  parameter int IMAGE_H   = 480,
  parameter int MIN_COUNT = 64,
  localparam int XW = $clog2(IMAGE_W),
  localparam int YW = $clog2(IMAGE_H),
  localparam int CW = $clog2(IMAGE_W * IMAGE_H + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [2:0]    pixel_classification,
  input  logic [2:0]    rd_class,
  output logic [XW-1:0] rd_x_min,
  output logic [XW-1:0] rd_x_max,
  output logic [YW-1:0] rd_y_min,
  output logic [YW-1:0] rd_y_max,
  output logic [CW-1:0] rd_count,
  output logic          rd_found,
  output logic          frame_done,
  output logic          frame_error,
  output logic          busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);
  // The line counter carries one extra bit so it can sit at IMAGE_H once the
  // frame has overrun, which marks every further beat as out of range.
  localparam logic [YW:0]   Y_LIM  = (YW + 1)'(IMAGE_H);
  localparam logic [YW:0]   Y_LAST = (YW + 1)'(IMAGE_H - 1);
  localparam logic [YW-1:0] Y_INIT = YW'(IMAGE_H - 1);

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [XW-1:0] r_x;
  logic [YW:0]   r_y;
  logic          r_err;
  logic          r_commit;
  logic          r_commit_err;

  logic          w_accept;
  logic          w_end;
  logic [XW-1:0] w_cur_x;
  logic [YW:0]   w_cur_y;
  logic          w_in_range;
  logic          w_hit;
  logic [XW-1:0] w_x_nxt;
  logic [YW:0]   w_y_nxt;
  logic          w_err_nxt;
  logic          w_eop_bad;

  // Working sets (index 0 is never hit; background has no box)
  logic [XW-1:0] r_wx_min [8];
  logic [XW-1:0] r_wx_max [8];
  logic [YW-1:0] r_wy_min [8];
  logic [YW-1:0] r_wy_max [8];
  logic [CW-1:0] r_w_cnt  [8];
  logic [XW-1:0] w_nx_min [8];
  logic [XW-1:0] w_nx_max [8];
  logic [YW-1:0] w_ny_min [8];
  logic [YW-1:0] w_ny_max [8];
  logic [CW-1:0] w_n_cnt  [8];

  // Result bank
  logic [XW-1:0] r_bk_x_min [8];
  logic [XW-1:0] r_bk_x_max [8];
  logic [YW-1:0] r_bk_y_min [8];
  logic [YW-1:0] r_bk_y_max [8];
  logic [CW-1:0] r_bk_cnt   [8];

  // A beat is taken when it starts a frame or arrives inside one. An sop beat
  // always restarts at (0,0), abandoning any frame in progress.
  assign w_accept   = in_valid && (in_sop || (r_state == S_ACTIVE));
  assign w_end      = w_accept && in_eop;
  assign w_cur_x    = in_sop ? '0 : r_x;
  assign w_cur_y    = in_sop ? '0 : r_y;
  assign w_in_range = (w_cur_y < Y_LIM);
  assign w_hit      = w_accept && w_in_range && (pixel_classification != 3'd0);
  assign w_eop_bad  = (w_cur_x != X_LAST) || (w_cur_y != Y_LAST);

  assign busy = (r_state == S_ACTIVE);

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = in_eop ? S_IDLE : S_ACTIVE;
    end
  end

  always_comb begin
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_err_nxt = r_err;
    if (w_accept) begin
      if (w_cur_x == X_LAST) begin
        w_x_nxt = '0;
        w_y_nxt = w_in_range ? (w_cur_y + (YW + 1)'(1)) : w_cur_y;
      end else begin
        w_x_nxt = w_cur_x + XW'(1);
        w_y_nxt = w_cur_y;
      end
      w_err_nxt = (in_sop ? 1'b0 : r_err) | ~w_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_err        <= 1'b0;
      r_commit     <= 1'b0;
      r_commit_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_err        <= w_err_nxt;
      // The eop pixel lands in the working sets on this edge; the bank copy
      // follows on the next edge so it sees the completed sets.
      r_commit     <= w_end;
      r_commit_err <= w_err_nxt | w_eop_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate: on sop the sets start from an empty box, then the sop pixel
  // is folded in on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_nx_min[k] = r_wx_min[k];
      w_nx_max[k] = r_wx_max[k];
      w_ny_min[k] = r_wy_min[k];
      w_ny_max[k] = r_wy_max[k];
      w_n_cnt[k]  = r_w_cnt[k];
      if (in_valid && in_sop) begin
        w_nx_min[k] = X_LAST;
        w_nx_max[k] = '0;
        w_ny_min[k] = Y_INIT;
        w_ny_max[k] = '0;
        w_n_cnt[k]  = '0;
      end
      if (w_hit && (pixel_classification == 3'(k))) begin
        if (w_cur_x < w_nx_min[k])              w_nx_min[k] = w_cur_x;
        if (w_cur_x > w_nx_max[k])              w_nx_max[k] = w_cur_x;
        if (w_cur_y[YW-1:0] < w_ny_min[k])      w_ny_min[k] = w_cur_y[YW-1:0];
        if (w_cur_y[YW-1:0] > w_ny_max[k])      w_ny_max[k] = w_cur_y[YW-1:0];
        if (w_n_cnt[k] != {CW{1'b1}})           w_n_cnt[k]  = w_n_cnt[k] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        r_wx_min[k] <= '0;
        r_wx_max[k] <= '0;
        r_wy_min[k] <= '0;
        r_wy_max[k] <= '0;
        r_w_cnt[k]  <= '0;
      end
    end else begin
      r_wx_min <= w_nx_min;
      r_wx_max <= w_nx_max;
      r_wy_min <= w_ny_min;
      r_wy_max <= w_ny_max;
      r_w_cnt  <= w_n_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Commit: bank copy and the frame_done / frame_error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        r_bk_x_min[k] <= '0;
        r_bk_x_max[k] <= '0;
        r_bk_y_min[k] <= '0;
        r_bk_y_max[k] <= '0;
        r_bk_cnt[k]   <= '0;
      end
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (r_commit) begin
        r_bk_x_min <= r_wx_min;
        r_bk_x_max <= r_wx_max;
        r_bk_y_min <= r_wy_min;
        r_bk_y_max <= r_wy_max;
        r_bk_cnt   <= r_w_cnt;
      end
      frame_done  <= r_commit;
      frame_error <= r_commit & r_commit_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Readout: registered; background and empty classes read as all zeros
  // ---------------------------------------------------------------------------
  logic w_rd_empty;
  assign w_rd_empty = (rd_class == 3'd0) || (r_bk_cnt[rd_class] == '0);

  always_ff @(posedge clk) begin
    if (rst || w_rd_empty) begin
      rd_x_min <= '0;
      rd_x_max <= '0;
      rd_y_min <= '0;
      rd_y_max <= '0;
      rd_count <= '0;
      rd_found <= 1'b0;
    end else begin
      rd_x_min <= r_bk_x_min[rd_class];
      rd_x_max <= r_bk_x_max[rd_class];
      rd_y_min <= r_bk_y_min[rd_class];
      rd_y_max <= r_bk_y_max[rd_class];
      rd_count <= r_bk_cnt[rd_class];
      rd_found <= ({{(32 - CW){1'b0}}, r_bk_cnt[rd_class]} >= 32'(MIN_COUNT));
    end
  end

endmodule

// File: tb/tb_pixel_bbox_tracker.sv
// -----------------------------------------------------------------------------
// Bench for pixel_bbox_tracker. Instance A is an 8x4 image (MIN_COUNT=2) driven
// by directed and randomized frames and checked against a frame-level model
// (position = beat index within the frame). Instance B is a 2x2 image used for
// the overrun case.
// -----------------------------------------------------------------------------
module tb_pixel_bbox_tracker;
  localparam int W = 8, H = 4, MINC = 2;
  localparam int AXW = $clog2(W), AYW = $clog2(H), ACW = $clog2(W * H + 1);
  localparam int CMAX = (1 << ACW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic           a_valid, a_sop, a_eop;
  logic [2:0]     a_cls, a_rdc;
  logic [AXW-1:0] a_xmin, a_xmax;
  logic [AYW-1:0] a_ymin, a_ymax;
  logic [ACW-1:0] a_cnt;
  logic           a_found, a_done, a_ferr, a_busy;

  logic           b_valid, b_sop, b_eop;
  logic [2:0]     b_cls, b_rdc;
  logic [0:0]     b_xmin, b_xmax, b_ymin, b_ymax;
  logic [2:0]     b_cnt;
  logic           b_found, b_done, b_ferr, b_busy;

  pixel_bbox_tracker #(.IMAGE_W(W), .IMAGE_H(H), .MIN_COUNT(MINC)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_sop(a_sop), .in_eop(a_eop),
    .pixel_classification(a_cls), .rd_class(a_rdc),
    .rd_x_min(a_xmin), .rd_x_max(a_xmax), .rd_y_min(a_ymin), .rd_y_max(a_ymax),
    .rd_count(a_cnt), .rd_found(a_found), .frame_done(a_done),
    .frame_error(a_ferr), .busy(a_busy));

  pixel_bbox_tracker #(.IMAGE_W(2), .IMAGE_H(2), .MIN_COUNT(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_sop(b_sop), .in_eop(b_eop),
    .pixel_classification(b_cls), .rd_class(b_rdc),
    .rd_x_min(b_xmin), .rd_x_max(b_xmax), .rd_y_min(b_ymin), .rd_y_max(b_ymax),
    .rd_count(b_cnt), .rd_found(b_found), .frame_done(b_done),
    .frame_error(b_ferr), .busy(b_busy));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // frame_done pulse monitors
  int   a_done_cnt = 0, b_done_cnt = 0;
  logic a_last_err = 1'b0;
  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      a_done_cnt++;
      a_last_err = a_ferr;
    end
    if (b_done === 1'b1) b_done_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Frame-level reference model for instance A
  // ---------------------------------------------------------------------------
  bit m_act = 0;
  int m_n = 0;
  bit m_err = 0;
  int m_xmin[8], m_xmax[8], m_ymin[8], m_ymax[8], m_cnt[8];
  int k_xmin[8], k_xmax[8], k_ymin[8], k_ymax[8], k_cnt[8];
  int exp_done = 0;
  bit exp_err = 0;

  function automatic void model_clear_bank();
    for (int i = 0; i < 8; i++) begin
      k_xmin[i] = 0; k_xmax[i] = 0; k_ymin[i] = 0; k_ymax[i] = 0; k_cnt[i] = 0;
    end
  endfunction

  function automatic void model_beat(bit v, bit s, bit e, int c);
    int x, y;
    if (!v) return;
    if (s) begin
      m_act = 1; m_n = 0; m_err = 0;
      for (int i = 0; i < 8; i++) begin
        m_xmin[i] = 1000; m_xmax[i] = -1; m_ymin[i] = 1000; m_ymax[i] = -1; m_cnt[i] = 0;
      end
    end else if (!m_act) begin
      return;
    end
    x = m_n % W;
    y = m_n / W;
    if (y < H) begin
      if (c != 0) begin
        if (x < m_xmin[c]) m_xmin[c] = x;
        if (x > m_xmax[c]) m_xmax[c] = x;
        if (y < m_ymin[c]) m_ymin[c] = y;
        if (y > m_ymax[c]) m_ymax[c] = y;
        if (m_cnt[c] < CMAX) m_cnt[c]++;
      end
    end else begin
      m_err = 1;
    end
    m_n++;
    if (e) begin
      for (int i = 0; i < 8; i++) begin
        k_xmin[i] = m_xmin[i]; k_xmax[i] = m_xmax[i];
        k_ymin[i] = m_ymin[i]; k_ymax[i] = m_ymax[i]; k_cnt[i] = m_cnt[i];
      end
      exp_done++;
      exp_err = m_err || (x != W - 1) || (y != H - 1);
      m_act = 0;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle_a(input int n);
    a_valid = 0; a_sop = 0; a_eop = 0;
    repeat (n) @(negedge clk);
  endtask

  // One valid beat, optionally preceded by random stall cycles carrying junk
  task automatic beat_a(input bit s, input bit e, input int c, input bit stall);
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        a_valid = 0; a_sop = 1'($urandom); a_eop = 1'($urandom); a_cls = 3'($urandom);
        @(negedge clk);
      end
    end
    a_valid = 1; a_sop = s; a_eop = e; a_cls = 3'(c);
    model_beat(1'b1, s, e, c);
    @(negedge clk);
  endtask

  task automatic read_all_a(input string tag);
    int ex0, ex1, ey0, ey1, ec, ef;
    for (int c = 0; c < 8; c++) begin
      a_rdc = 3'(c);
      @(negedge clk);
      if (c == 0 || k_cnt[c] == 0) begin
        ex0 = 0; ex1 = 0; ey0 = 0; ey1 = 0; ec = 0; ef = 0;
      end else begin
        ex0 = k_xmin[c]; ex1 = k_xmax[c]; ey0 = k_ymin[c]; ey1 = k_ymax[c];
        ec = k_cnt[c]; ef = (k_cnt[c] >= MINC) ? 1 : 0;
      end
      chk($sformatf("%s_c%0d_xmin", tag, c), 32'(a_xmin), ex0);
      chk($sformatf("%s_c%0d_xmax", tag, c), 32'(a_xmax), ex1);
      chk($sformatf("%s_c%0d_ymin", tag, c), 32'(a_ymin), ey0);
      chk($sformatf("%s_c%0d_ymax", tag, c), 32'(a_ymax), ey1);
      chk($sformatf("%s_c%0d_cnt", tag, c), 32'(a_cnt), ec);
      chk($sformatf("%s_c%0d_found", tag, c), 32'(a_found), ef);
    end
  endtask

  task automatic frame_check_a(input string tag);
    chk({tag, "_done_cnt"}, a_done_cnt, exp_done);
    chk({tag, "_ferr"}, 32'(a_last_err), 32'(exp_err));
    read_all_a(tag);
  endtask

  function automatic int blob_cls(int n);
    return (n == 10 || n == 13 || n == 19) ? 3 : 0;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1;
    a_valid = 0; a_sop = 0; a_eop = 0; a_cls = 0; a_rdc = 3;
    b_valid = 0; b_sop = 0; b_eop = 0; b_cls = 0; b_rdc = 7;
    model_clear_bank();
    repeat (3) @(negedge clk);
    chk("rst_busy_a", 32'(a_busy), 0);
    chk("rst_done_a", 32'(a_done), 0);
    chk("rst_ferr_a", 32'(a_ferr), 0);
    chk("rst_cnt_a", 32'(a_cnt), 0);
    chk("rst_xmax_a", 32'(a_xmax), 0);
    chk("rst_found_a", 32'(a_found), 0);
    chk("rst_busy_b", 32'(b_busy), 0);
    rst = 0;
    @(negedge clk);

    // Overrun on the 2x2 instance: 4 pixels, 2 extra beats, then eop
    for (int n = 0; n < 7; n++) begin
      b_valid = 1; b_sop = (n == 0); b_eop = (n == 6); b_cls = 3'd7;
      @(negedge clk);
    end
    b_valid = 0; b_sop = 0; b_eop = 0;
    @(negedge clk);
    chk("s6_done", 32'(b_done), 1);
    chk("s6_ferr", 32'(b_ferr), 1);
    @(negedge clk);
    chk("s6_cnt", 32'(b_cnt), 4);
    chk("s6_xmin", 32'(b_xmin), 0);
    chk("s6_xmax", 32'(b_xmax), 1);
    chk("s6_ymin", 32'(b_ymin), 0);
    chk("s6_ymax", 32'(b_ymax), 1);
    chk("s6_found", 32'(b_found), 1);
    chk("s6_done_cnt", b_done_cnt, 1);

    // Single blob, no stalls; commit pulse timing
    for (int n = 0; n < 32; n++) begin
      beat_a(n == 0, n == 31, blob_cls(n), 1'b0);
      if (n == 0) chk("s1_busy_rise", 32'(a_busy), 1);
    end
    a_valid = 0; a_sop = 0; a_eop = 0;
    chk("s1_busy_fall", 32'(a_busy), 0);
    chk("s1_done_early", 32'(a_done), 0);
    @(negedge clk);
    chk("s1_done_pulse", 32'(a_done), 1);
    chk("s1_ferr_pulse", 32'(a_ferr), 0);
    @(negedge clk);
    chk("s1_done_end", 32'(a_done), 0);
    chk("s1_c3_xmin_const", 32'(a_xmin), 2);
    chk("s1_c3_cnt_const", 32'(a_cnt), 3);
    frame_check_a("s1");

    // Same frame with random stalls and junk on invalid cycles
    for (int n = 0; n < 32; n++) beat_a(n == 0, n == 31, blob_cls(n), 1'b1);
    idle_a(3);
    frame_check_a("s2");

    // Short frame ending at (7,2)
    for (int n = 0; n < 24; n++)
      beat_a(n == 0, n == 23, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7)), 1'b1);
    idle_a(3);
    frame_check_a("s3");

    // Abandoned frame followed by a clean frame with class 2 at (0,0)
    for (int n = 0; n < 10; n++) beat_a(n == 0, 1'b0, (n % 3 == 0) ? 1 : 0, 1'b0);
    for (int n = 0; n < 32; n++) beat_a(n == 0, n == 31, (n == 0) ? 2 : 0, 1'b0);
    idle_a(3);
    frame_check_a("s4");

    // One-pixel frame (sop and eop together), then eop alone in IDLE
    beat_a(1'b1, 1'b1, 4, 1'b0);
    chk("sx_busy", 32'(a_busy), 0);
    idle_a(3);
    beat_a(1'b0, 1'b1, 5, 1'b0);
    idle_a(3);
    frame_check_a("sx");

    // Randomized frames: full, short and overrunning lengths
    for (int f = 0; f < 8; f++) begin
      int len;
      case ($urandom_range(0, 3))
        0, 1:    len = 32;
        2:       len = int'($urandom_range(1, 31));
        default: len = int'($urandom_range(33, 40));
      endcase
      for (int n = 0; n < len; n++)
        beat_a(n == 0, n == len - 1,
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0, 1'b1);
      idle_a(3);
      frame_check_a($sformatf("rnd%0d", f));
    end

    // Pre-sop beats are ignored
    for (int n = 0; n < 6; n++) beat_a(1'b0, 1'($urandom), int'($urandom_range(0, 7)), 1'b0);
    chk("s5_presop_busy", 32'(a_busy), 0);
    idle_a(3);
    chk("s5_presop_done", a_done_cnt, exp_done);

    // Reset in the middle of a frame
    for (int n = 0; n < 12; n++) beat_a(n == 0, 1'b0, int'($urandom_range(1, 7)), 1'b0);
    a_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_act = 0;
    model_clear_bank();
    idle_a(3);
    chk("s5_rst_busy", 32'(a_busy), 0);
    chk("s5_rst_done", a_done_cnt, exp_done);
    read_all_a("s5");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
